// File: rtl/btn_debounce_pkg.sv
// -----------------------------------------------------------------------------
// btn_debounce_pkg
//   Shared constants and helpers for the multi-channel button debouncer.
//   Default timing constants assume a 50 MHz clock and a 1 ms tick.
//   cnt_width() sizes a counter that must hold values 0..max_val.
// -----------------------------------------------------------------------------
package btn_debounce_pkg;

    localparam int TICK_DIV_1MS_50MHZ = 50000;
    localparam int DEBOUNCE_10MS      = 10;
    localparam int HOLD_500MS         = 500;
    localparam int REPEAT_100MS       = 100;

    // Width of a counter that must represent 0..max_val (never less than 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_tick_gen.sv
// -----------------------------------------------------------------------------
// btn_tick_gen
//   Free-running prescaler shared by all button channels. Counts
//   0..TICK_DIV-1 and raises tick for one clock when the count is TICK_DIV-1.
//
//   Ports:
//     clk   in   system clock
//     rst   in   asynchronous, active-high reset
//     tick  out  one-cycle pulse every TICK_DIV clocks
// -----------------------------------------------------------------------------
module btn_tick_gen
    import btn_debounce_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_1MS_50MHZ
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = cnt_width(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_button_debounce.sv
// -----------------------------------------------------------------------------
// multi_button_debounce
//   N independent button channels sharing one tick prescaler. Each channel:
//   2-flop synchroniser, optional inversion, tick-based debounce counter,
//   registered press/release pulses and a long-press level.
//
//   Optional feature macro: BTN_AUTOREPEAT_EN
//     defined   -> btn_down also pulses when btn_long rises and then every
//                  REPEAT_TICKS ticks while the button stays pressed.
//     undefined -> btn_down pulses only on a press commit.
//
//   Ports:
//     clk        in   system clock
//     rst        in   asynchronous, active-high reset
//     btn_in     in   raw button pins
//     btn_state  out  debounced level, 1 = pressed
//     btn_down   out  one-cycle press pulse per channel
//     btn_up     out  one-cycle release pulse per channel
//     btn_long   out  high while held for at least HOLD_TICKS ticks
// -----------------------------------------------------------------------------
module multi_button_debounce
    import btn_debounce_pkg::*;
#(
    parameter int N_BTN          = 4,
    parameter int TICK_DIV       = TICK_DIV_1MS_50MHZ,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_10MS,
    parameter int HOLD_TICKS     = HOLD_500MS,
    parameter int REPEAT_TICKS   = REPEAT_100MS,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] btn_down,
    output logic [N_BTN-1:0] btn_up,
    output logic [N_BTN-1:0] btn_long
);

    localparam int DEB_W  = cnt_width(DEBOUNCE_TICKS - 1);
    localparam int HOLD_W = cnt_width(HOLD_TICKS);
    localparam int REP_W  = cnt_width(REPEAT_TICKS - 1);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
    // Inactive pin level; also what the synchronisers reset to.
    localparam logic INV = (ACTIVE_LOW != 0);

    if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_err
        $error("multi_button_debounce: TICK_DIV must be >= 2, DEBOUNCE_TICKS and REPEAT_TICKS >= 1");
    end

    logic tick;

    btn_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic              sync1_q, sync2_q;
        logic              s;
        logic              state_q, state_d;
        logic [DEB_W-1:0]  deb_q, deb_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              long_q, long_d;
        logic              down_q, down_d;
        logic              up_q, up_d;

        assign s = sync2_q ^ INV;

        // NOTE: every always_comb output gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            deb_d   = deb_q;
            if (s == state_q) begin
                deb_d = '0;
            end else if (tick) begin
                if (deb_q == DEB_MAX) begin
                    state_d = s;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end

            hold_d = hold_q;
            if (!state_q) begin
                hold_d = '0;
            end else if (tick && hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
            end

            // Gating with state_d makes a release on the threshold tick win,
            // and drops btn_long in the same cycle btn_state falls.
            long_d = state_d && (hold_d == HOLD_MAX);
            up_d   = state_q && !state_d;
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [REP_W-1:0] rep_q, rep_d;
        logic             rep_fire;

        // rep_cnt runs only once btn_long is up; it restarts from 0 whenever
        // btn_long is low, which also covers the clear on release.
        always_comb begin
            rep_d    = rep_q;
            rep_fire = 1'b0;
            if (!long_q) begin
                rep_d = '0;
            end else if (tick) begin
                if (rep_q == REP_W'(REPEAT_TICKS - 1)) begin
                    rep_d    = '0;
                    rep_fire = 1'b1;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
            down_d = (state_d && !state_q) || (long_d && !long_q) || (rep_fire && state_d);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rep_q <= '0;
            end else begin
                rep_q <= rep_d;
            end
        end
`else
        assign down_d = state_d && !state_q;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q <= INV;
                sync2_q <= INV;
                state_q <= 1'b0;
                deb_q   <= '0;
                hold_q  <= '0;
                long_q  <= 1'b0;
                down_q  <= 1'b0;
                up_q    <= 1'b0;
            end else begin
                sync1_q <= btn_in[i];
                sync2_q <= sync1_q;
                state_q <= state_d;
                deb_q   <= deb_d;
                hold_q  <= hold_d;
                long_q  <= long_d;
                down_q  <= down_d;
                up_q    <= up_d;
            end
        end

        assign btn_state[i] = state_q;
        assign btn_down[i]  = down_q;
        assign btn_up[i]    = up_q;
        assign btn_long[i]  = long_q;
    end

endmodule

// File: tb/tb_multi_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_multi_button_debounce
//   Bench for multi_button_debounce with N_BTN=4, TICK_DIV=4, DEBOUNCE_TICKS=3,
//   HOLD_TICKS=5, REPEAT_TICKS=2. An active-high instance is driven with the
//   pins, an active-low twin with the inverted pins; their outputs must match.
//   Press/release pulses are logged by a monitor and checked against expected
//   events (channel, kind, cycle window) queued when stimulus is applied.
//   With TICK_DIV=4 and DEBOUNCE_TICKS=3 a clean edge commits 11..14 cycles
//   after the pin changes, and btn_long follows btn_state by 5 ticks = 20 cycles.
// -----------------------------------------------------------------------------
module tb_multi_button_debounce;

    localparam int N = 4;

    typedef struct {
        int ch;
        int kind;   // 0 = down pulse, 1 = up pulse
        int lo;
        int hi;
    } exp_t;

    typedef struct {
        int ch;
        int kind;
        int cyc;
    } got_t;

    typedef struct {
        int ch;
        int hi_cycles;
        bit press;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pin;
    logic [N-1:0] pin_n;
    logic [N-1:0] a_state, a_down, a_up, a_long;
    logic [N-1:0] b_state, b_down, b_up, b_long;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    got_t got_q[$];

    assign pin_n = ~pin;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    multi_button_debounce #(
        .N_BTN(N), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .HOLD_TICKS(5),
        .REPEAT_TICKS(2), .ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_in(pin),
        .btn_state(a_state), .btn_down(a_down), .btn_up(a_up), .btn_long(a_long)
    );

    multi_button_debounce #(
        .N_BTN(N), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .HOLD_TICKS(5),
        .REPEAT_TICKS(2), .ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_in(pin_n),
        .btn_state(b_state), .btn_down(b_down), .btn_up(b_up), .btn_long(b_long)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        n_cmp++;
        if (actual < lo || actual > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic push_exp(input int ch, input int kind, input int lo, input int hi);
        exp_q.push_back('{ch, kind, lo, hi});
    endtask

    // Drain the scoreboard: every expected event must match the next logged one.
    task automatic compare_sb(input string name);
        exp_t e;
        got_t g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s: missing ch%0d kind%0d in cycles %0d..%0d",
                         name, e.ch, e.kind, e.lo, e.hi);
            end else begin
                g = got_q.pop_front();
                if (g.ch != e.ch || g.kind != e.kind || g.cyc < e.lo || g.cyc > e.hi) begin
                    n_bad++;
                    $display("FAIL %s: got ch%0d kind%0d @%0d, want ch%0d kind%0d @%0d..%0d",
                             name, g.ch, g.kind, g.cyc, e.ch, e.kind, e.lo, e.hi);
                end
            end
        end
        check({name, "_extra_events"}, got_q.size(), 0);
        got_q.delete();
    endtask

    function automatic logic sig(input int which, input int ch);
        case (which)
            0:       return a_state[ch];
            1:       return a_down[ch];
            2:       return a_up[ch];
            default: return a_long[ch];
        endcase
    endfunction

    // Bounded wait on a DUT output; an expired budget is a failed comparison.
    task automatic wait_sig(input int which, input int ch, input int budget,
                            input string name, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sig(which, ch) == 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
    endtask

    // Pulse monitor plus the active-low equivalence check.
    always @(negedge clk) begin
        check("active_low_twin", int'({b_state, b_down, b_up, b_long}),
                                 int'({a_state, a_down, a_up, a_long}));
        if (!rst) begin
            for (int c = 0; c < N; c++) begin
                if (a_down[c]) got_q.push_back('{c, 0, cyc});
                if (a_up[c])   got_q.push_back('{c, 1, cyc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   t0, t1, ts, cs, cl, cr;
        logic prev_long;

        vecs = '{'{0, 15, 1'b1},   // clean press/release on ch0
                 '{2,  3, 1'b0},   // glitch shorter than one tick period
                 '{3,  8, 1'b0},   // spans only two ticks: never commits
                 '{1, 12, 1'b1},   // spans exactly three ticks: always commits
                 '{2, 15, 1'b1}};

        rst = 1'b1;
        pin = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({a_state, a_down, a_up, a_long}), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        got_q.delete();

        // Table-driven presses and glitches.
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            t0 = cyc;
            pin[vecs[v].ch] = 1'b1;
            if (vecs[v].press) push_exp(vecs[v].ch, 0, t0 + 11, t0 + 14);
            repeat (vecs[v].hi_cycles) @(negedge clk);
            pin[vecs[v].ch] = 1'b0;
            t1 = cyc;
            if (vecs[v].press) push_exp(vecs[v].ch, 1, t1 + 11, t1 + 14);
            repeat (40 - vecs[v].hi_cycles) @(negedge clk);
            compare_sb($sformatf("vec%0d", v));
        end

        // Bounce on ch1: toggles every 3 cycles, ends high.
        @(negedge clk);
        ts = cyc;
        for (int k = 0; k < 13; k++) begin
            pin[1] = ~pin[1];
            ts = cyc;
            repeat (3) @(negedge clk);
        end
        push_exp(1, 0, ts + 11, ts + 14);
        repeat (17) @(negedge clk);
        compare_sb("bounce");
        rst = 1'b1;
        pin = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        got_q.delete();

        // Long hold on ch2 for 30 ticks, then release.
        @(negedge clk);
        t0 = cyc;
        pin[2] = 1'b1;
        wait_sig(0, 2, 20, "hold_press", cs);
        check_range("hold_press_latency", cs - t0, 11, 14);
        wait_sig(3, 2, 40, "hold_long", cl);
        check("long_after_5_ticks", cl - cs, 20);
        while (cyc < t0 + 120) @(negedge clk);
        pin[2] = 1'b0;
        t1 = cyc;
        prev_long = a_long[2];
        cr = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (a_up[2]) begin
                cr = cyc;
                break;
            end
            prev_long = a_long[2];
        end
        if (cr < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL hold_release: no btn_up within 20 cycles");
        end
        check("long_high_before_up", int'(prev_long), 1);
        check("long_falls_with_up", int'(a_long[2]), 0);
        check_range("release_latency", cr - t1, 11, 14);
        push_exp(2, 0, cs, cs);
`ifdef BTN_AUTOREPEAT_EN
        push_exp(2, 0, cl, cl);
        for (int c = cl + 8; c < cr; c += 8) push_exp(2, 0, c, c);
`endif
        push_exp(2, 1, cr, cr);
        repeat (3) @(negedge clk);
        compare_sb("hold");

        // Reset while ch0 is held, then release reset with the pin still high.
        @(negedge clk);
        t0 = cyc;
        pin[0] = 1'b1;
        push_exp(0, 0, t0 + 11, t0 + 14);
        wait_sig(0, 0, 20, "rst_press", cs);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async_outputs", int'({a_state, a_down, a_up, a_long}), 0);
        compare_sb("pre_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t1 = cyc;
        push_exp(0, 0, t1 + 11, t1 + 14);
        repeat (15) @(negedge clk);
        compare_sb("post_reset_press");
        pin[0] = 1'b0;
        t1 = cyc;
        push_exp(0, 1, t1 + 11, t1 + 14);
        repeat (20) @(negedge clk);
        compare_sb("post_reset_release");

        // Simultaneous press on ch0 and ch3.
        @(negedge clk);
        t0 = cyc;
        pin[0] = 1'b1;
        pin[3] = 1'b1;
        push_exp(0, 0, t0 + 11, t0 + 14);
        push_exp(3, 0, t0 + 11, t0 + 14);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (a_down[0] || a_down[3]) break;
        end
        check("same_cycle_down", int'({a_down[3], a_down[0]}), 3);
        while (cyc < t0 + 15) @(negedge clk);
        pin[0] = 1'b0;
        pin[3] = 1'b0;
        t1 = cyc;
        push_exp(0, 1, t1 + 11, t1 + 14);
        push_exp(3, 1, t1 + 11, t1 + 14);
        repeat (20) @(negedge clk);
        compare_sb("simultaneous");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
